sram_access_controller: RTL and testbench
=========================================

# sram_access_controller

Request-side controller sitting directly upstream of the on-chip SRAM wrapper. Accepts single or burst read/write requests over valid/ready handshakes, sequences them into one-access-per-cycle SRAM strobes, and returns read data through a back-pressurable response port. It guarantees the SRAM never sees read and write enables asserted together.

## Interface
Parameters:
- ADDR_BITS, 16, SRAM word-address width (64K one-byte words)
- DATA_BITS, 32, access width (4 words x 8 bits)
- WORDS_PER_ACCESS, 4, address stride per beat
- LEN_BITS, 4, burst length field width (beats = req_len + 1, max 16)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock, 6 ns period
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  request offered
- req_ready  out  1  request accepted this cycle when both high
- req_write  in  1  1 = write burst, 0 = read burst
- req_addr  in  ADDR_BITS  first word address
- req_len  in  LEN_BITS  beats minus one
- wr_valid  in  1  write beat data offered
- wr_data  in  DATA_BITS  write beat data
- wr_ready  out  1  write beat consumed when both high
- rsp_valid  out  1  read data held
- rsp_data  out  DATA_BITS  read data
- rsp_last  out  1  final beat of read burst
- rsp_ready  in  1  consumer accepts response
- done  out  1  one-cycle pulse at burst completion
- err  out  1  one-cycle pulse on rejected request
- sram_read_enable  out  1  to wrapper read_enable
- sram_write_enable  out  1  to wrapper write_enable
- sram_address  out  ADDR_BITS  to wrapper address
- sram_write_data  out  DATA_BITS  to wrapper write_data
- sram_read_data  in  DATA_BITS  from wrapper read_data

## Operation
- States: IDLE, WRITE, READ. Reset -> IDLE.
- IDLE: req_ready=1. On req_valid: latch cur_addr=req_addr, beats_left=req_len; go WRITE if req_write else READ.
- WRITE: wr_ready=1. Each cycle with wr_valid: sram_write_enable=1, sram_write_data=wr_data, sram_address=cur_addr; cur_addr += WORDS_PER_ACCESS; beats_left -= 1. No wr_valid -> no access, state held. Last beat -> IDLE, done pulses next cycle.
- READ: issue slot free when rsp_valid=0 or rsp_ready=1. If free: sram_read_enable=1 at cur_addr, advance address/counter. Data captured into response register at the closing edge; rsp_last set on final beat. Last issue -> IDLE. done pulses the cycle after the rsp_last handshake.
- cur_addr arithmetic is modulo 2^ADDR_BITS (0xFFFC + 4 -> 0x0000) when bounds checking is compiled out.
- sram_read_enable and sram_write_enable mutually exclusive by construction; both 0 in IDLE.
- sram_address = cur_addr at all times; sram_write_data = wr_data gated to 0 when not writing.
- A new request may be accepted in IDLE while a previous rsp_last is still pending; its first read waits for the slot.

## Timing
- Reset values: req_ready 0 during rst then 1; wr_ready 0; rsp_valid 0; rsp_data 0; rsp_last 0; done 0; err 0; all sram_* 0.
- Request handshake to first SRAM strobe: 1 cycle.
- Read latency: strobe in cycle N -> rsp_valid high cycle N+1. Sustained throughput 1 beat/cycle with rsp_ready held high.
- Write throughput 1 beat/cycle with wr_valid held high.
- rsp_valid/rsp_data/rsp_last stable until rsp_ready handshake.
- rst asserted mid-burst: immediately IDLE, enables drop asynchronously, pending response discarded, no done.

## Configuration
- SRAM_CTRL_BOUNDS_CHECK_EN defined: in IDLE, a request with req_addr not a multiple of WORDS_PER_ACCESS, or whose final beat address exceeds 2^ADDR_BITS - WORDS_PER_ACCESS, is handshaken but discarded: err pulses next cycle, no SRAM access, no wr_ready, state stays IDLE.
- Undefined: no checks, addresses wrap silently, err tied 0.

## Structure
- Package sram_ctrl_pkg: state enum, ADDR_BITS/DATA_BITS/WORDS_PER_ACCESS/LEN_BITS defaults, helper function for final-beat address.
- Sub-module sram_rsp_reg: single-entry response holding register (data, last, valid) with load/accept handshake.

## Test plan
- Write 1 beat 0xFFFFFFFF at 0x0000, then read 1 beat at 0x0000 -> rsp_data 0xFFFFFFFF one cycle after strobe, rsp_last 1, done after handshake.
- Write burst len=3 at 0x0008 data 5,6,7,8 -> addresses 0x0008,0x000C,0x0010,0x0014; read back same burst -> 5,6,7,8 with rsp_last only on 8.
- Read burst len=3 with rsp_ready toggled 1,0,0,1,... -> no lost or duplicated beats, no strobe while slot held.
- Write burst wr_valid gapped every other cycle -> write strobes only on valid cycles, never both enables high.
- Request at 0xFFFC len=1 -> with SRAM_CTRL_BOUNDS_CHECK_EN err pulse, no strobes; without, second beat at 0x0000.
- rst asserted during read beat 2 of 4 -> all outputs 0 immediately, next request starts cleanly.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared state type, default widths and address helper for the SRAM access controller.
package sram_ctrl_pkg;

    localparam int unsigned ADDR_BITS_DEFAULT        = 16;
    localparam int unsigned DATA_BITS_DEFAULT        = 32;
    localparam int unsigned WORDS_PER_ACCESS_DEFAULT = 4;
    localparam int unsigned LEN_BITS_DEFAULT         = 4;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ
    } state_t;

    // Address of the last beat of a burst, computed without wrap so overflow is visible.
    function automatic logic [31:0] final_beat_addr(input logic [31:0] addr,
                                                    input logic [31:0] len,
                                                    input logic [31:0] stride);
        return addr + len * stride;
    endfunction

endpackage

// File: rtl/sram_rsp_reg.sv
// Single-entry read response holding register with load/accept handshake.
module sram_rsp_reg
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_BITS = DATA_BITS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] load_data,
    input  logic                 load_last,
    input  logic                 accept,
    output logic                 valid,
    output logic [DATA_BITS-1:0] data,
    output logic                 last
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            last  <= load_last;
        end else if (accept) begin
            valid <= 1'b0;
            last  <= 1'b0;
        end
    end

endmodule

// File: rtl/sram_access_controller.sv
// Sequences single/burst read and write requests into one SRAM access per cycle.
// Optional request bounds checking: SRAM_CTRL_BOUNDS_CHECK_EN.
module sram_access_controller
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_BITS        = ADDR_BITS_DEFAULT,
    parameter int unsigned DATA_BITS        = DATA_BITS_DEFAULT,
    parameter int unsigned WORDS_PER_ACCESS = WORDS_PER_ACCESS_DEFAULT,
    parameter int unsigned LEN_BITS         = LEN_BITS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [LEN_BITS-1:0]  req_len,
    input  logic                 wr_valid,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 wr_ready,
    output logic                 rsp_valid,
    output logic [DATA_BITS-1:0] rsp_data,
    output logic                 rsp_last,
    input  logic                 rsp_ready,
    output logic                 done,
    output logic                 err,
    output logic                 sram_read_enable,
    output logic                 sram_write_enable,
    output logic [ADDR_BITS-1:0] sram_address,
    output logic [DATA_BITS-1:0] sram_write_data,
    input  logic [DATA_BITS-1:0] sram_read_data
);

    state_t               state;
    logic [ADDR_BITS-1:0] cur_addr;
    logic [LEN_BITS-1:0]  beats_left;
    logic                 last_beat;
    logic                 slot_free;
    logic                 write_en;
    logic                 read_en;
    logic                 req_fire;
    logic                 rsp_fire;
    logic                 req_bad;

    assign req_ready = (state == IDLE) && !rst;
    assign wr_ready  = (state == WRITE);
    assign last_beat = (beats_left == '0);
    assign slot_free = !rsp_valid || rsp_ready;
    assign write_en  = (state == WRITE) && wr_valid;
    assign read_en   = (state == READ) && slot_free;
    assign req_fire  = req_valid && req_ready;
    assign rsp_fire  = rsp_valid && rsp_ready;

    // Enables decode from a single state, so read and write can never coincide.
    assign sram_write_enable = write_en;
    assign sram_read_enable  = read_en;
    assign sram_address      = cur_addr;
    assign sram_write_data   = write_en ? wr_data : '0;

`ifdef SRAM_CTRL_BOUNDS_CHECK_EN
    logic err_q;

    assign req_bad = ((32'(req_addr) % 32'(WORDS_PER_ACCESS)) != 32'd0) ||
                     (final_beat_addr(32'(req_addr), 32'(req_len), 32'(WORDS_PER_ACCESS)) >
                      ((32'd1 << ADDR_BITS) - 32'(WORDS_PER_ACCESS)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= req_fire && req_bad;
    end

    assign err = err_q;
`else
    assign req_bad = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cur_addr   <= '0;
            beats_left <= '0;
            done       <= 1'b0;
        end else begin
            done <= (write_en && last_beat) || (rsp_fire && rsp_last);
            case (state)
                IDLE: begin
                    if (req_fire && !req_bad) begin
                        cur_addr   <= req_addr;
                        beats_left <= req_len;
                        state      <= req_write ? WRITE : READ;
                    end
                end
                WRITE, READ: begin
                    if (write_en || read_en) begin
                        cur_addr   <= cur_addr + ADDR_BITS'(WORDS_PER_ACCESS);
                        beats_left <= beats_left - LEN_BITS'(1);
                        if (last_beat) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sram_rsp_reg #(
        .DATA_BITS(DATA_BITS)
    ) u_rsp_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (read_en),
        .load_data(sram_read_data),
        .load_last(last_beat),
        .accept   (rsp_ready),
        .valid    (rsp_valid),
        .data     (rsp_data),
        .last     (rsp_last)
    );

endmodule

// File: tb/tb_sram_access_controller.sv
// Bench for sram_access_controller: SRAM stub, transaction-level model, directed bursts.
`timescale 1ns/1ps
module tb_sram_access_controller;

    localparam int unsigned AW  = 16;
    localparam int unsigned DW  = 32;
    localparam int unsigned WPA = 4;
    localparam int unsigned LW  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [LW-1:0] req_len = '0;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_last;
    logic          rsp_ready = 1'b0;
    logic          done;
    logic          err;
    logic          sram_read_enable;
    logic          sram_write_enable;
    logic [AW-1:0] sram_address;
    logic [DW-1:0] sram_write_data;
    logic [DW-1:0] sram_read_data;

    int errors = 0;
    int checks = 0;

    always #3 clk = ~clk;

    sram_access_controller #(
        .ADDR_BITS(AW),
        .DATA_BITS(DW),
        .WORDS_PER_ACCESS(WPA),
        .LEN_BITS(LW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_ready(rsp_ready),
        .done(done), .err(err),
        .sram_read_enable(sram_read_enable), .sram_write_enable(sram_write_enable),
        .sram_address(sram_address), .sram_write_data(sram_write_data),
        .sram_read_data(sram_read_data)
    );

    // SRAM stub: combinational read, write on the clock edge.
    logic [DW-1:0] stub_mem [0:65535];
    assign sram_read_data = sram_read_enable ? stub_mem[sram_address] : '0;

    initial begin
        for (int i = 0; i < 65536; i++) stub_mem[i] = '0;
        forever begin
            @(posedge clk);
            if (sram_write_enable) stub_mem[sram_address] = sram_write_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Observed-traffic logs, compared against hand-computed literals by the directed tests.
    logic [31:0] rsp_log[$];
    logic [31:0] last_log[$];
    logic [31:0] wa_log[$];
    int          done_cnt = 0;
    int          err_cnt = 0;

    // Behavioural model: burst bookkeeping plus a memory image.
    logic [31:0] m_mem [0:65535];
    int          m_kind;        // 0 none, 1 write burst, 2 read burst
    int unsigned m_cur;
    int          m_left;
    bit          m_rv, m_rl, m_done, m_err;
    logic [31:0] m_rd;

    initial begin : model
        bit e_we, e_re, e_free, n_done, n_err, bad;
        for (int i = 0; i < 65536; i++) m_mem[i] = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_kind = 0; m_cur = 0; m_left = 0;
                m_rv = 0; m_rl = 0; m_rd = '0; m_done = 0; m_err = 0;
            end
            e_we   = (m_kind == 1) && wr_valid;
            e_free = !m_rv || rsp_ready;
            e_re   = (m_kind == 2) && e_free;
            chk("req_ready", 32'(req_ready), 32'((m_kind == 0) && !rst));
            chk("wr_ready", 32'(wr_ready), 32'(m_kind == 1));
            chk("sram_write_enable", 32'(sram_write_enable), 32'(e_we));
            chk("sram_read_enable", 32'(sram_read_enable), 32'(e_re));
            chk("sram_address", 32'(sram_address), m_cur);
            chk("sram_write_data", sram_write_data, e_we ? wr_data : 32'h0);
            chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
            chk("rsp_data", rsp_data, m_rd);
            chk("rsp_last", 32'(rsp_last), 32'(m_rl));
            chk("done", 32'(done), 32'(m_done));
            chk("err", 32'(err), 32'(m_err));
            if (!rst) begin
                if (rsp_valid && rsp_ready) begin
                    rsp_log.push_back(rsp_data);
                    last_log.push_back(32'(rsp_last));
                end
                if (sram_write_enable) wa_log.push_back(32'(sram_address));
                if (done) done_cnt++;
                if (err) err_cnt++;

                n_done = m_rv && rsp_ready && m_rl;
                n_err  = 0;
                if (e_re) begin
                    m_rv = 1; m_rd = m_mem[m_cur]; m_rl = (m_left == 0);
                end else if (m_rv && rsp_ready) begin
                    m_rv = 0; m_rl = 0;
                end
                case (m_kind)
                    0: if (req_valid) begin
`ifdef SRAM_CTRL_BOUNDS_CHECK_EN
                        bad = (req_addr % 4 != 0) || (32'(req_addr) + 32'(req_len) * 4 > 65532);
`else
                        bad = 0;
`endif
                        if (bad) n_err = 1;
                        else begin
                            m_kind = req_write ? 1 : 2;
                            m_cur  = req_addr;
                            m_left = req_len;
                        end
                    end
                    1: if (wr_valid) begin
                        m_mem[m_cur] = wr_data;
                        if (m_left == 0) begin n_done = 1; m_kind = 0; end
                        m_left--;
                        m_cur = (m_cur + 4) % 65536;
                    end
                    default: if (e_re) begin
                        if (m_left == 0) m_kind = 0;
                        m_left--;
                        m_cur = (m_cur + 4) % 65536;
                    end
                endcase
                m_done = n_done;
                m_err  = n_err;
            end
        end
    end

    logic [31:0] wq[$];
    logic [31:0] exp_q[$];
    int          exp_done = 0;

    task automatic chk_q(input string name, input logic [31:0] act[$], input logic [31:0] exp[$]);
        chk({name, "_count"}, 32'(act.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < act.size(); i++)
            chk(name, act[i], exp[i]);
    endtask

    task automatic clear_logs();
        rsp_log.delete(); last_log.delete(); wa_log.delete();
    endtask

    task automatic send_req(input bit w, input logic [AW-1:0] a, input logic [LW-1:0] l);
        req_valid = 1'b1; req_write = w; req_addr = a; req_len = l;
        @(negedge clk);
        chk("req_accept", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic write_beats(input bit gap);
        for (int i = 0; i < wq.size(); i++) begin
            wr_valid = 1'b1; wr_data = wq[i];
            @(negedge clk);
            chk("wr_beat_ready", 32'(wr_ready), 32'd1);
            @(posedge clk); #1;
            if (gap) begin
                wr_valid = 1'b0; wr_data = '0;
                @(posedge clk); #1;
            end
        end
        wr_valid = 1'b0; wr_data = '0;
    endtask

    task automatic wait_done();
        int n = 0;
        exp_done++;
        while (done_cnt < exp_done && n < 60) begin
            @(posedge clk); n++;
        end
        chk("done_reached", 32'(done_cnt >= exp_done), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit rpat[$];
        int snap;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_sram_addr", 32'(sram_address), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single write then single read at 0x0000.
        wq = '{32'hFFFF_FFFF};
        send_req(1, 16'h0000, 4'd0);
        write_beats(0);
        wait_done();
        rsp_ready = 1'b1;
        send_req(0, 16'h0000, 4'd0);
        wait_done();
        exp_q = '{32'hFFFF_FFFF};
        chk_q("single_read", rsp_log, exp_q);
        exp_q = '{32'd1};
        chk_q("single_last", last_log, exp_q);
        clear_logs();

        // Four-beat write burst at 0x0008 and read back.
        wq = '{32'd5, 32'd6, 32'd7, 32'd8};
        send_req(1, 16'h0008, 4'd3);
        write_beats(0);
        wait_done();
        exp_q = '{32'h8, 32'hC, 32'h10, 32'h14};
        chk_q("burst_wr_addr", wa_log, exp_q);
        send_req(0, 16'h0008, 4'd3);
        wait_done();
        exp_q = '{32'd5, 32'd6, 32'd7, 32'd8};
        chk_q("burst_rd_data", rsp_log, exp_q);
        exp_q = '{32'd0, 32'd0, 32'd0, 32'd1};
        chk_q("burst_rd_last", last_log, exp_q);
        clear_logs();

        // Same read with a back-pressured consumer.
        rpat = '{1, 0, 0, 1, 0, 1, 0, 0, 1, 1, 0, 1};
        rsp_ready = 1'b0;
        send_req(0, 16'h0008, 4'd3);
        foreach (rpat[i]) begin
            rsp_ready = rpat[i];
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        wait_done();
        exp_q = '{32'd5, 32'd6, 32'd7, 32'd8};
        chk_q("bp_rd_data", rsp_log, exp_q);
        clear_logs();

        // Gapped write burst at 0x0020, then read back.
        wq = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
        send_req(1, 16'h0020, 4'd3);
        write_beats(1);
        wait_done();
        exp_q = '{32'h20, 32'h24, 32'h28, 32'h2C};
        chk_q("gap_wr_addr", wa_log, exp_q);
        send_req(0, 16'h0020, 4'd3);
        wait_done();
        exp_q = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
        chk_q("gap_rd_data", rsp_log, exp_q);
        clear_logs();

        // Reset during beat 2 of a 4-beat read.
        send_req(0, 16'h0008, 4'd3);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_read_en", 32'(sram_read_enable), 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_rsp_data", rsp_data, 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        chk("midrst_sram_addr", 32'(sram_address), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        snap = done_cnt;
        clear_logs();
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_no_done", 32'(done_cnt), 32'(snap));
        send_req(0, 16'h0000, 4'd0);
        wait_done();
        exp_q = '{32'hFFFF_FFFF};
        chk_q("post_rst_read", rsp_log, exp_q);
        clear_logs();

        // Burst crossing the top of the address space.
`ifdef SRAM_CTRL_BOUNDS_CHECK_EN
        snap = done_cnt;
        send_req(1, 16'hFFFC, 4'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("wrap_err_cnt", 32'(err_cnt), 32'd1);
        chk("wrap_no_strobe", 32'(wa_log.size()), 32'd0);
        send_req(0, 16'h0002, 4'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("misalign_err_cnt", 32'(err_cnt), 32'd2);
        chk("reject_no_done", 32'(done_cnt), 32'(snap));
`else
        wq = '{32'h11, 32'h22};
        send_req(1, 16'hFFFC, 4'd1);
        write_beats(0);
        wait_done();
        exp_q = '{32'hFFFC, 32'h0000};
        chk_q("wrap_wr_addr", wa_log, exp_q);
        send_req(0, 16'hFFFC, 4'd1);
        wait_done();
        exp_q = '{32'h11, 32'h22};
        chk_q("wrap_rd_data", rsp_log, exp_q);
        chk("wrap_no_err", 32'(err_cnt), 32'd0);
`endif

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
